// File: rtl/mcb_port_model.sv
// Behavioural responder for one MCB user port: command/write/read FIFOs in front of a word RAM.
// Calibrates after reset, then executes WRITE, READ and REFRESH commands strictly in order.
module mcb_port_model #(
    parameter int MEM_AW         = 10,
    parameter int CMD_DEPTH      = 4,
    parameter int CALIB_CYCLES   = 64,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        calib_done,
    input  logic        cmd_en,
    input  logic [2:0]  cmd_instr,
    input  logic [5:0]  cmd_bl,
    input  logic [29:0] cmd_byte_addr,
    output logic        cmd_empty,
    output logic        cmd_full,
    input  logic        wr_en,
    input  logic [3:0]  wr_mask,
    input  logic [31:0] wr_data,
    output logic        wr_full,
    output logic        wr_empty,
    output logic [6:0]  wr_count,
    output logic        wr_underrun,
    output logic        wr_error,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_full,
    output logic        rd_empty,
    output logic [6:0]  rd_count,
    output logic        rd_overflow,
    output logic        rd_error
);
    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int CW  = $clog2((CALIB_CYCLES > REFRESH_CYCLES ? CALIB_CYCLES : REFRESH_CYCLES) + 1);

    typedef enum logic [2:0] {S_CALIB, S_IDLE, S_WRITE, S_READ, S_REFRESH} state_t;
    typedef struct packed {
        logic [2:0]        instr;
        logic [5:0]        bl;
        logic [MEM_AW-1:0] addr;
    } cmd_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [6:0]        len_q, len_d;

    logic cmd_push, cmd_pop, wr_push, wr_pop, rd_push, rd_pop;
    logic underrun_d, overflow_d;
    logic wr_underrun_q, rd_overflow_q, wr_error_q, rd_error_q;
    logic [31:0] ram_rdata;

    // ---------------- command FIFO ----------------
    cmd_t           cmd_mem [CMD_DEPTH];
    logic [CPW-1:0] cmd_wp_q, cmd_rp_q;
    logic [CPW:0]   cmd_cnt_q;
    cmd_t           cmd_head;

    assign cmd_empty = (cmd_cnt_q == '0);
    assign cmd_full  = (cmd_cnt_q == (CPW+1)'(CMD_DEPTH));
    assign cmd_push  = cmd_en && calib_done && !cmd_full;
    assign cmd_head  = cmd_mem[cmd_rp_q];

    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem[cmd_wp_q] <= {cmd_instr, cmd_bl, cmd_byte_addr[MEM_AW+1:2]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            cmd_cnt_q <= '0;
        end else begin
            if (cmd_push) cmd_wp_q <= cmd_wp_q + CPW'(1);
            if (cmd_pop)  cmd_rp_q <= cmd_rp_q + CPW'(1);
            if (cmd_push && !cmd_pop)      cmd_cnt_q <= cmd_cnt_q + (CPW+1)'(1);
            else if (!cmd_push && cmd_pop) cmd_cnt_q <= cmd_cnt_q - (CPW+1)'(1);
        end
    end

    // ---------------- write FIFO: {mask, data} ----------------
    logic [35:0] wr_mem [64];
    logic [5:0]  wr_wp_q, wr_rp_q;
    logic [6:0]  wr_cnt_q;
    logic [35:0] wr_head;

    assign wr_empty = (wr_cnt_q == 7'd0);
    assign wr_full  = (wr_cnt_q == 7'd64);
    assign wr_count = wr_cnt_q;
    assign wr_push  = wr_en && !wr_full;
    assign wr_head  = wr_mem[wr_rp_q];

    always_ff @(posedge clk) begin
        if (wr_push) wr_mem[wr_wp_q] <= {wr_mask, wr_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_wp_q  <= '0;
            wr_rp_q  <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (wr_push) wr_wp_q <= wr_wp_q + 6'd1;
            if (wr_pop)  wr_rp_q <= wr_rp_q + 6'd1;
            if (wr_push && !wr_pop)      wr_cnt_q <= wr_cnt_q + 7'd1;
            else if (!wr_push && wr_pop) wr_cnt_q <= wr_cnt_q - 7'd1;
        end
    end

    // ---------------- read FIFO (first-word-fall-through) ----------------
    logic [31:0] rd_mem [64];
    logic [5:0]  rd_wp_q, rd_rp_q;
    logic [6:0]  rd_cnt_q;

    assign rd_empty = (rd_cnt_q == 7'd0);
    assign rd_full  = (rd_cnt_q == 7'd64);
    assign rd_count = rd_cnt_q;
    assign rd_pop   = rd_en && !rd_empty;
    assign rd_data  = rd_empty ? 32'd0 : rd_mem[rd_rp_q];

    always_ff @(posedge clk) begin
        if (rd_push) rd_mem[rd_wp_q] <= ram_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wp_q  <= '0;
            rd_rp_q  <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (rd_push) rd_wp_q <= rd_wp_q + 6'd1;
            if (rd_pop)  rd_rp_q <= rd_rp_q + 6'd1;
            if (rd_push && !rd_pop)      rd_cnt_q <= rd_cnt_q + 7'd1;
            else if (!rd_push && rd_pop) rd_cnt_q <= rd_cnt_q - 7'd1;
        end
    end

    // ---------------- word RAM, one array per byte lane so masks map to lane enables ----------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [2**MEM_AW];
            always_ff @(posedge clk) begin
                if (wr_pop && !wr_head[32+gi])
                    lane_mem[addr_q] <= wr_head[gi*8 +: 8];
            end
            assign ram_rdata[gi*8 +: 8] = lane_mem[addr_q];
        end
    endgenerate

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CALIB;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        addr_d  = addr_q;
        len_d   = len_q;
        case (state_q)
            S_CALIB: begin
                if (cnt_q == CW'(CALIB_CYCLES - 1)) state_d = S_IDLE;
                else                                cnt_d   = cnt_q + CW'(1);
            end
            S_IDLE: begin
                if (!cmd_empty) begin
                    addr_d = cmd_head.addr;
                    len_d  = {1'b0, cmd_head.bl} + 7'd1;
                    if (cmd_head.instr[2])      state_d = S_REFRESH;
                    else if (cmd_head.instr[0]) state_d = S_READ;
                    else                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_pop) begin
                    addr_d = addr_q + MEM_AW'(1);
                    len_d  = len_q - 7'd1;
                    if (len_q == 7'd1) state_d = S_IDLE;
                end
            end
            S_READ: begin
                // Address and length advance even when the word is dropped on a full FIFO.
                addr_d = addr_q + MEM_AW'(1);
                len_d  = len_q - 7'd1;
                if (len_q == 7'd1) state_d = S_IDLE;
            end
            S_REFRESH: begin
                if (cnt_q == CW'(REFRESH_CYCLES - 1)) state_d = S_IDLE;
                else                                  cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = S_CALIB;
        endcase
    end

    always_comb begin
        calib_done = (state_q != S_CALIB);
        cmd_pop    = (state_q == S_IDLE) && !cmd_empty;
        wr_pop     = (state_q == S_WRITE) && !wr_empty;
        underrun_d = (state_q == S_WRITE) && wr_empty;
        rd_push    = (state_q == S_READ) && !rd_full;
        overflow_d = (state_q == S_READ) && rd_full;
    end

    // ---------------- status pulses and sticky errors ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_underrun_q <= 1'b0;
            rd_overflow_q <= 1'b0;
            wr_error_q    <= 1'b0;
            rd_error_q    <= 1'b0;
        end else begin
            wr_underrun_q <= underrun_d;
            rd_overflow_q <= overflow_d;
            wr_error_q    <= wr_error_q | underrun_d | (wr_en && wr_full);
            rd_error_q    <= rd_error_q | overflow_d | (rd_en && rd_empty);
        end
    end

    assign wr_underrun = wr_underrun_q;
    assign rd_overflow = rd_overflow_q;
    assign wr_error    = wr_error_q;
    assign rd_error    = rd_error_q;

    logic unused_bits;
    assign unused_bits = ^{cmd_byte_addr[29:MEM_AW+2], cmd_byte_addr[1:0], cmd_head.instr[1]};

endmodule

// File: tb/tb_mcb_port_model.sv
// Directed bench for mcb_port_model: a byte-mask word model feeds a queue of expected read words,
// which are popped and compared as the read FIFO presents them.
module tb_mcb_port_model;
    logic        clk = 1'b0;
    logic        rst;
    logic        calib_done;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_empty, cmd_full;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        wr_full, wr_empty, wr_underrun, wr_error;
    logic [6:0]  wr_count;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_full, rd_empty, rd_overflow, rd_error;
    logic [6:0]  rd_count;

    always #5 clk = ~clk;

    mcb_port_model dut (
        .clk(clk), .rst(rst), .calib_done(calib_done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .cmd_empty(cmd_empty), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
        .wr_full(wr_full), .wr_empty(wr_empty), .wr_count(wr_count),
        .wr_underrun(wr_underrun), .wr_error(wr_error),
        .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
        .rd_count(rd_count), .rd_overflow(rd_overflow), .rd_error(rd_error)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_model [1024];
    logic [35:0] wq [$];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] d, input logic [3:0] m, input bit track);
        wr_data = d; wr_mask = m; wr_en = 1'b1;
        if (track) wq.push_back({m, d});
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic issue_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] a);
        cmd_instr = instr; cmd_bl = bl; cmd_byte_addr = a; cmd_en = 1'b1;
        @(negedge clk);
        cmd_en = 1'b0;
    endtask

    // Apply the next n queued write words to the model starting at word address a.
    task automatic model_burst(input logic [9:0] a, input int n);
        logic [35:0] w;
        for (int i = 0; i < n; i++) begin
            w = wq.pop_front();
            for (int b = 0; b < 4; b++)
                if (!w[32+b]) mem_model[a][b*8 +: 8] = w[b*8 +: 8];
            a = a + 10'd1;
        end
    endtask

    task automatic expect_burst(input logic [9:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem_model[a]);
            a = a + 10'd1;
        end
    endtask

    task automatic wait_quiet(input string tag, input int bound);
        int t = 0;
        while (!(cmd_empty && wr_empty) && t < bound) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        check(tag, {cmd_empty, wr_empty}, 2'b11);
    endtask

    task automatic wait_rd_count(input string tag, input logic [6:0] n, input int bound);
        int t = 0;
        while (rd_count != n && t < bound) begin @(negedge clk); t++; end
        check(tag, rd_count, n);
    endtask

    task automatic drain(input int n);
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (rd_empty && t < 100) begin @(negedge clk); t++; end
            check("rd_avail", rd_empty, 1'b0);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            check("rd_data", rd_data, e);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
    endtask

    initial begin
        int cyc, pulses;
        rst = 1'b1; cmd_en = 0; cmd_instr = 0; cmd_bl = 0; cmd_byte_addr = 0;
        wr_en = 0; wr_mask = 0; wr_data = 0; rd_en = 0;
        repeat (3) @(negedge clk);

        check("rst_calib_done", calib_done, 0);
        check("rst_empties", {cmd_empty, wr_empty, rd_empty}, 3'b111);
        check("rst_fulls", {cmd_full, wr_full, rd_full}, 3'b000);
        check("rst_counts", {wr_count, rd_count}, 14'd0);
        check("rst_pulses_errors", {wr_underrun, rd_overflow, wr_error, rd_error}, 4'b0000);
        check("rst_rd_data", rd_data, 32'd0);

        // Release reset; a command offered during calibration must be dropped.
        rst = 1'b0;
        cyc = 0;
        cmd_instr = 3'b000; cmd_bl = 6'd0; cmd_byte_addr = 30'd0; cmd_en = 1'b1;
        while (!calib_done && cyc < 200) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (cyc == 2) cmd_en = 1'b0;
            if (cyc == 3) check("cmd_ignored_in_calib", cmd_empty, 1'b1);
        end
        check("calib_latency", cyc, 64);
        check("cmd_empty_after_calib", cmd_empty, 1'b1);

        // Basic burst write and readback.
        for (int i = 0; i < 4; i++) push_wr(32'hA0 + i, 4'h0, 1'b1);
        check("wr_count_4", wr_count, 7'd4);
        issue_cmd(3'b000, 6'd3, 30'h100);
        model_burst(10'h040, 4);
        wait_quiet("quiet_wr_a", 200);
        check("wr_count_0", wr_count, 7'd0);
        issue_cmd(3'b001, 6'd3, 30'h100);
        expect_burst(10'h040, 4);
        wait_rd_count("rd_count_4", 7'd4, 100);
        drain(4);
        check("rd_count_0", rd_count, 7'd0);
        check("rd_empty_after_drain", rd_empty, 1'b1);

        // Byte mask: second write keeps bytes 0 and 2 from the first.
        push_wr(32'hFFFF_FFFF, 4'b0000, 1'b1);
        push_wr(32'h1234_5678, 4'b0101, 1'b1);
        issue_cmd(3'b010, 6'd0, 30'h0);
        issue_cmd(3'b000, 6'd0, 30'h0);
        model_burst(10'h000, 1);
        model_burst(10'h000, 1);
        wait_quiet("quiet_wr_mask", 200);
        issue_cmd(3'b011, 6'd0, 30'h0);
        exp_q.push_back(32'h12FF_56FF);
        drain(1);
        check("wr_error_clean", wr_error, 1'b0);

        // Underrun: 8-word burst with 4 words queued, 4 more arriving later.
        for (int i = 0; i < 4; i++) push_wr(32'hB0 + i, 4'h0, 1'b1);
        check("wr_count_pre_underrun", wr_count, 7'd4);
        issue_cmd(3'b000, 6'd7, 30'h200);
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (wr_underrun) pulses++;
            if (k >= 8 && k <= 11) begin
                wr_data = 32'hB0 + (k - 4); wr_mask = 4'h0; wr_en = 1'b1;
                wq.push_back({4'h0, 32'hB0 + (k - 4)});
            end else begin
                wr_en = 1'b0;
            end
        end
        check("underrun_pulses", pulses, 4);
        check("wr_error_sticky", wr_error, 1'b1);
        model_burst(10'h080, 8);
        wait_quiet("quiet_wr_underrun", 100);
        issue_cmd(3'b001, 6'd7, 30'h200);
        expect_burst(10'h080, 8);
        drain(8);

        // Fill the write FIFO, then overflow the read FIFO with two 64-word reads.
        for (int i = 0; i < 64; i++)
            push_wr({8'(i), 8'hC3, 8'(~i), 8'h3C}, (i == 0) ? 4'b1010 : 4'b0000, 1'b1);
        check("wr_full_64", wr_full, 1'b1);
        check("wr_count_64", wr_count, 7'd64);
        push_wr(32'hDEAD_BEEF, 4'h0, 1'b0);
        check("wr_push_while_full", wr_count, 7'd64);
        issue_cmd(3'b000, 6'd63, 30'h0);
        model_burst(10'h000, 64);
        wait_quiet("quiet_wr_64", 300);
        check("rd_error_clean", rd_error, 1'b0);
        issue_cmd(3'b001, 6'd63, 30'h0);
        issue_cmd(3'b011, 6'd63, 30'h100);
        expect_burst(10'h000, 64);
        pulses = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rd_overflow) pulses++;
        end
        check("rd_count_64", rd_count, 7'd64);
        check("rd_full_64", rd_full, 1'b1);
        check("overflow_pulses", pulses, 64);
        check("rd_error_sticky", rd_error, 1'b1);
        drain(64);
        check("rd_empty_after_64", rd_empty, 1'b1);

        // Command FIFO full: a read offered while full must never execute.
        for (int i = 0; i < 5; i++) issue_cmd(3'b100, 6'd0, 30'h0);
        check("cmd_full", cmd_full, 1'b1);
        issue_cmd(3'b001, 6'd0, 30'h0);
        check("cmd_full_hold", cmd_full, 1'b1);
        repeat (100) @(negedge clk);
        check("cmd_drained", cmd_empty, 1'b1);
        check("dropped_cmd_no_read", rd_count, 7'd0);

        // Address wrap at the top word, upper byte-address bits ignored, REFRESH leaves RAM alone.
        push_wr(32'hC0C0_C0C0, 4'h0, 1'b1);
        push_wr(32'hC1C1_C1C1, 4'h0, 1'b1);
        issue_cmd(3'b000, 6'd1, 30'h2000_0FFC);
        model_burst(10'h3FF, 2);
        wait_quiet("quiet_wr_wrap", 100);
        issue_cmd(3'b110, 6'd0, 30'h0);
        issue_cmd(3'b001, 6'd1, 30'h0FFC);
        exp_q.push_back(32'hC0C0_C0C0);
        exp_q.push_back(32'hC1C1_C1C1);
        drain(2);
        issue_cmd(3'b001, 6'd0, 30'h4);
        expect_burst(10'h001, 1);
        drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
